// File: rtl/piggy_report_engine.sv
// piggy_report_engine: per-channel saturating BCD coin counters plus a report
// streamer. A report snapshots every counter and sends one ASCII frame:
// channel 0 first, DIGITS decimal digits per channel (leading zeros kept),
// SEP_CHAR between channels, then CR LF.
//
// Output handshake: a byte moves when tx_valid and tx_ready are both high at a
// rising clk edge. Once tx_valid is raised, tx_valid and tx_data hold their
// values until that transfer happens; only rst may drop tx_valid early.
module piggy_report_engine #(
  parameter int          N_CH        = 4,
  parameter int          DIGITS      = 3,
  parameter int          AUTO_REPORT = 1,
  parameter logic [7:0]  SEP_CHAR    = 8'h20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] coin,
  input  logic            clear,
  input  logic            report_req,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic            busy,
  output logic            frame_done,
  output logic [N_CH-1:0] overflow
);

  localparam int         CW       = 4 * DIGITS;
  localparam logic [2:0] LAST_CH  = 3'(N_CH - 1);
  localparam logic [2:0] TOP_DIG  = 3'(DIGITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DIGIT = 3'd2,
    S_SEP   = 3'd3,
    S_CR    = 3'd4,
    S_LF    = 3'd5
  } state_e;

  // Counter state
  logic [CW-1:0]   cnt_q  [N_CH];
  logic [CW-1:0]   cnt_d  [N_CH];
  logic [N_CH-1:0] ovf_q, ovf_d;

  // Report state
  state_e          state_q, state_d;
  logic [2:0]      ch_q, ch_d;
  logic [2:0]      dig_q, dig_d;
  logic            pending_q, pending_d;
  logic [CW-1:0]   snap_q [N_CH];
  logic [CW-1:0]   snap_d [N_CH];

  // Registered outputs
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic            busy_q, busy_d;
  logic            frame_done_q, frame_done_d;

  logic            trigger;
  logic            accept;
  logic [CW-1:0]   sel_val;
  logic [3:0]      sel_dig;

  // True when every BCD digit of v is 9 (counter is saturated).
  function automatic logic is_max(input logic [CW-1:0] v);
    logic r;
    r = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (v[4*d +: 4] != 4'd9) r = 1'b0;
    end
    return r;
  endfunction

  // Decimal increment with carry rippling from the least significant digit.
  function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (carry) begin
        if (r[4*d +: 4] == 4'd9) begin
          r[4*d +: 4] = 4'd0;
        end else begin
          r[4*d +: 4] = r[4*d +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign trigger = report_req | ((AUTO_REPORT != 0) & ((|coin) | clear));
  assign accept  = tx_valid_q & tx_ready;

  // Next counter values: clear beats coin; a coin at all-9s only flags overflow.
  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (coin[i]) begin
        if (is_max(cnt_q[i])) ovf_d[i] = 1'b1;
        else                  cnt_d[i] = bcd_inc(cnt_q[i]);
      end
    end
  end

  // Counter and overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
      ovf_q <= ovf_d;
    end
  end

  // Frame sequencing: next state, byte position and pending re-trigger.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    dig_d     = dig_q;
    pending_d = pending_q;
    for (int i = 0; i < N_CH; i++) snap_d[i] = snap_q[i];

    if (state_q != S_IDLE && trigger) pending_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (trigger) state_d = S_LOAD;
      end
      S_LOAD: begin
        // Snapshot the registered counts, which already include any
        // increment made on the triggering cycle.
        for (int i = 0; i < N_CH; i++) snap_d[i] = cnt_q[i];
        ch_d    = 3'd0;
        dig_d   = TOP_DIG;
        state_d = S_DIGIT;
      end
      S_DIGIT: begin
        if (accept) begin
          if (dig_q != 3'd0)        dig_d   = dig_q - 3'd1;
          else if (ch_q != LAST_CH) state_d = S_SEP;
          else                      state_d = S_CR;
        end
      end
      S_SEP: begin
        if (accept) begin
          ch_d    = ch_q + 3'd1;
          dig_d   = TOP_DIG;
          state_d = S_DIGIT;
        end
      end
      S_CR: begin
        if (accept) state_d = S_LF;
      end
      S_LF: begin
        if (accept) begin
          state_d   = (pending_q || trigger) ? S_LOAD : S_IDLE;
          pending_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output byte for the next cycle, taken from the snapshot that will be live.
  always_comb begin
    sel_val = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_d == 3'(i)) sel_val = snap_d[i];
    end
    sel_dig = 4'd0;
    for (int d = 0; d < DIGITS; d++) begin
      if (dig_d == 3'(d)) sel_dig = sel_val[4*d +: 4];
    end

    tx_valid_d   = 1'b0;
    tx_data_d    = 8'h00;
    unique case (state_d)
      S_DIGIT: begin tx_valid_d = 1'b1; tx_data_d = 8'h30 + {4'h0, sel_dig}; end
      S_SEP:   begin tx_valid_d = 1'b1; tx_data_d = SEP_CHAR;                end
      S_CR:    begin tx_valid_d = 1'b1; tx_data_d = 8'h0D;                   end
      S_LF:    begin tx_valid_d = 1'b1; tx_data_d = 8'h0A;                   end
      default: begin tx_valid_d = 1'b0; tx_data_d = 8'h00;                   end
    endcase
    busy_d       = (state_d != S_IDLE);
    frame_done_d = (state_q == S_LF) && accept;
  end

  // Report FSM registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ch_q         <= 3'd0;
      dig_q        <= 3'd0;
      pending_q    <= 1'b0;
      for (int i = 0; i < N_CH; i++) snap_q[i] <= '0;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      dig_q        <= dig_d;
      pending_q    <= pending_d;
      for (int i = 0; i < N_CH; i++) snap_q[i] <= snap_d[i];
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overflow   = ovf_q;

endmodule
